// File: rtl/reg_hl_arb.sv
// Two-requester arbiter that fills a split high/low register one byte at a time.
// Define REG_HL_RR_EN for round-robin tie-break; otherwise requester A has fixed priority.
module reg_hl_arb #(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned BW = WIDTH / 2
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          vld_a,
  input  logic          vld_b,
  input  logic [BW-1:0] data_a,
  input  logic [BW-1:0] data_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          rdy_a,
  output logic          rdy_b,
  output logic [BW-1:0] inh,
  output logic [BW-1:0] inl,
  output logic          loadh,
  output logic          loadl,
  output logic          reg_clr,
  output logic          word_valid,
  output logic          word_src,
  input  logic          word_ready,
  output logic [7:0]    word_cnt
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow, StFull} state_e;

  state_e        r_state;
  logic          r_gnt_a;
  logic          r_gnt_b;
  logic          r_word_valid;
  logic          r_word_src;
  logic [7:0]    r_word_cnt;

  logic          w_vld_g;
  logic          w_req_g;
  logic          w_busy;
  logic          w_abort;
  logic          w_pick_b;
  logic [BW-1:0] w_data;

`ifdef REG_HL_RR_EN
  logic          r_last_b;

  // On a tie, B wins only if A was granted last.
  always_comb begin
    w_pick_b = req_b & (~req_a | ~r_last_b);
  end
`else
  always_comb begin
    w_pick_b = req_b & ~req_a;
  end
`endif

  always_comb begin
    w_vld_g = (r_gnt_a & vld_a) | (r_gnt_b & vld_b);
    w_req_g = (r_gnt_a & req_a) | (r_gnt_b & req_b);
    w_busy  = (r_state == StHigh) | (r_state == StLow);
    w_abort = w_busy & ~w_req_g;
    w_data  = '0;
    if (!clear) begin
      if (r_gnt_a) begin
        w_data = data_a;
      end else if (r_gnt_b) begin
        w_data = data_b;
      end
    end
  end

  always_comb begin
    gnt_a      = r_gnt_a;
    gnt_b      = r_gnt_b;
    rdy_a      = r_gnt_a & vld_a & w_busy;
    rdy_b      = r_gnt_b & vld_b & w_busy;
    inh        = w_data;
    inl        = w_data;
    loadh      = (r_state == StHigh) & w_vld_g;
    loadl      = (r_state == StLow) & w_vld_g;
    reg_clr    = clear | w_abort;
    word_valid = r_word_valid;
    word_src   = r_word_src;
    word_cnt   = r_word_cnt;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state      <= StIdle;
      r_gnt_a      <= 1'b0;
      r_gnt_b      <= 1'b0;
      r_word_valid <= 1'b0;
      r_word_src   <= 1'b0;
      r_word_cnt   <= 8'd0;
`ifdef REG_HL_RR_EN
      r_last_b     <= 1'b1;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (req_a || req_b) begin
            r_gnt_a    <= ~w_pick_b;
            r_gnt_b    <= w_pick_b;
            r_word_src <= w_pick_b;
`ifdef REG_HL_RR_EN
            r_last_b   <= w_pick_b;
`endif
            r_state    <= StHigh;
          end
        end
        StHigh, StLow: begin
          if (w_abort) begin
            r_gnt_a <= 1'b0;
            r_gnt_b <= 1'b0;
            r_state <= StIdle;
          end else if (w_vld_g) begin
            if (r_state == StHigh) begin
              r_state <= StLow;
            end else begin
              r_state      <= StFull;
              r_word_valid <= 1'b1;
            end
          end
        end
        StFull: begin
          // Requester may drop req here; the completed word is still handed off.
          if (word_ready) begin
            r_gnt_a      <= 1'b0;
            r_gnt_b      <= 1'b0;
            r_word_valid <= 1'b0;
            r_word_cnt   <= r_word_cnt + 8'd1;
            r_state      <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_hl_arb.sv
// Self-checking bench for reg_hl_arb: per-scenario tasks plus a word scoreboard.
// Build with REG_HL_RR_EN defined or not; expected grant order follows the same macro.
module tb_reg_hl_arb;

  logic       clk;
  logic       clear;
  logic       req_a, req_b, vld_a, vld_b;
  logic [7:0] data_a, data_b;
  logic       gnt_a, gnt_b, rdy_a, rdy_b;
  logic [7:0] inh, inl;
  logic       loadh, loadl, reg_clr, word_valid, word_src, word_ready;
  logic [7:0] word_cnt;

  int checks;
  int errors;

  logic [16:0] sb[$];
  logic [7:0]  cap_hi, cap_lo;
  logic        s_gnt_a, s_gnt_b, s_rdy_a, s_rdy_b, s_loadh, s_loadl;
  logic        s_reg_clr, s_word_valid, s_word_src;
  logic [7:0]  s_inh, s_inl;

  reg_hl_arb #(.WIDTH(16)) dut (
    .clk        (clk),
    .clear      (clear),
    .req_a      (req_a),
    .req_b      (req_b),
    .vld_a      (vld_a),
    .vld_b      (vld_b),
    .data_a     (data_a),
    .data_b     (data_b),
    .gnt_a      (gnt_a),
    .gnt_b      (gnt_b),
    .rdy_a      (rdy_a),
    .rdy_b      (rdy_b),
    .inh        (inh),
    .inl        (inl),
    .loadh      (loadh),
    .loadl      (loadl),
    .reg_clr    (reg_clr),
    .word_valid (word_valid),
    .word_src   (word_src),
    .word_ready (word_ready),
    .word_cnt   (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] tb_byte(input logic b, input int idx);
    int w;
    logic [7:0] base;
    w    = idx / 2;
    base = b ? 8'hB0 : 8'h20;
    if (idx % 2 == 0) return 8'(w) ^ base;
    return 8'(w * 3) ^ base ^ 8'h0F;
  endfunction

  function automatic logic [16:0] exp_word(input logic b, input int w);
    return {b, tb_byte(b, 2 * w), tb_byte(b, 2 * w + 1)};
  endfunction

  // One clock: sample at negedge, run the word capture/scoreboard, return #1 after posedge.
  task automatic cyc();
    logic [16:0] exp;
    logic [16:0] got;
    @(negedge clk);
    s_gnt_a = gnt_a; s_gnt_b = gnt_b; s_rdy_a = rdy_a; s_rdy_b = rdy_b;
    s_loadh = loadh; s_loadl = loadl; s_reg_clr = reg_clr;
    s_word_valid = word_valid; s_word_src = word_src; s_inh = inh; s_inl = inl;
    if (s_loadh) cap_hi = inh;
    if (s_loadl) cap_lo = inl;
    if (s_loadh || s_loadl || s_rdy_a || s_rdy_b) begin
      checks++;
      if ((s_loadh && s_loadl) || (s_rdy_a && !s_gnt_a) || (s_rdy_b && !s_gnt_b)) begin
        errors++;
        $display("FAIL strobe_sanity: loadh=%b loadl=%b rdy_a=%b gnt_a=%b rdy_b=%b gnt_b=%b, required loads exclusive and rdy only with grant",
                 s_loadh, s_loadl, s_rdy_a, s_gnt_a, s_rdy_b, s_gnt_b);
      end
    end
    if (word_valid && word_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: word {src,hi,lo}=%h delivered, none expected",
                 {word_src, cap_hi, cap_lo});
      end else begin
        exp = sb.pop_front();
        got = {word_src, cap_hi, cap_lo};
        if (got !== exp) begin
          errors++;
          $display("FAIL word_delivered: got {src,hi,lo}=%h required %h", got, exp);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic idle_inputs();
    req_a = 0; req_b = 0; vld_a = 0; vld_b = 0; data_a = 0; data_b = 0; word_ready = 0;
  endtask

  // Requester models: each presents its next byte while it still has words to send.
  task automatic run_words(input int na, input int nb);
    int ai, bi, guard, limit;
    ai = 0; bi = 0; guard = 0;
    limit = 8 * (na + nb) + 20;
    word_ready = 1'b1;
    while (sb.size() != 0 && guard < limit) begin
      req_a = (ai < 2 * na); vld_a = req_a; data_a = tb_byte(1'b0, ai);
      req_b = (bi < 2 * nb); vld_b = req_b; data_b = tb_byte(1'b1, bi);
      cyc();
      if (s_rdy_a) ai++;
      if (s_rdy_b) bi++;
      guard++;
    end
    idle_inputs();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL run_words_timeout: %0d words still pending after %0d cycles, required 0",
               sb.size(), guard);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    clear = 1'b1;
    #2;
    checks++;
    if ({gnt_a, gnt_b, word_valid, word_src, loadh, loadl, reg_clr} !== 7'b0000001 ||
        word_cnt !== 8'd0 || inh !== 8'd0 || inl !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b%b wv=%b src=%b lh=%b ll=%b clr=%b cnt=%0d inh=%h inl=%h, required 0 except reg_clr=1",
               gnt_a, gnt_b, word_valid, word_src, loadh, loadl, reg_clr, word_cnt, inh, inl);
    end
    @(posedge clk);
    #1;
    clear = 1'b0;
    cyc();
    checks++;
    if (s_reg_clr !== 1'b0 || gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: reg_clr=%b gnt=%b%b, required 0 00", s_reg_clr, gnt_a, gnt_b);
    end
  endtask

  task automatic test_single();
    do_clear();
    sb.push_back({1'b0, 8'h12, 8'h34});
    req_a = 1'b1;
    cyc();
    checks++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || s_loadh !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: gnt_a=%b gnt_b=%b loadh=%b, required 1 0 0", gnt_a, gnt_b, s_loadh);
    end
    vld_a = 1'b1; data_a = 8'h12;
    cyc();
    checks++;
    if (s_loadh !== 1'b1 || s_loadl !== 1'b0 || s_inh !== 8'h12 || s_rdy_a !== 1'b1) begin
      errors++;
      $display("FAIL single_high: loadh=%b loadl=%b inh=%h rdy_a=%b, required 1 0 12 1",
               s_loadh, s_loadl, s_inh, s_rdy_a);
    end
    data_a = 8'h34;
    cyc();
    checks++;
    if (s_loadl !== 1'b1 || s_loadh !== 1'b0 || s_inl !== 8'h34 || s_word_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_low: loadl=%b loadh=%b inl=%h wv=%b, required 1 0 34 0",
               s_loadl, s_loadh, s_inl, s_word_valid);
    end
    // req dropped during FULL must not lose the word
    vld_a = 1'b0; req_a = 1'b0; word_ready = 1'b1;
    cyc();
    checks++;
    if (s_word_valid !== 1'b1 || s_word_src !== 1'b0 || s_rdy_a !== 1'b0) begin
      errors++;
      $display("FAIL single_full: word_valid=%b word_src=%b rdy_a=%b, required 1 0 0",
               s_word_valid, s_word_src, s_rdy_a);
    end
    checks++;
    if (word_cnt !== 8'd1 || gnt_a !== 1'b0 || word_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_done: word_cnt=%0d gnt_a=%b word_valid=%b, required 1 0 0",
               word_cnt, gnt_a, word_valid);
    end
    idle_inputs();
  endtask

  task automatic test_tie();
    do_clear();
`ifdef REG_HL_RR_EN
    sb.push_back(exp_word(1'b0, 0)); sb.push_back(exp_word(1'b1, 0));
    sb.push_back(exp_word(1'b0, 1)); sb.push_back(exp_word(1'b1, 1));
`else
    sb.push_back(exp_word(1'b0, 0)); sb.push_back(exp_word(1'b0, 1));
    sb.push_back(exp_word(1'b1, 0)); sb.push_back(exp_word(1'b1, 1));
`endif
    run_words(2, 2);
    checks++;
    if (word_cnt !== 8'd4) begin
      errors++;
      $display("FAIL tie_count: word_cnt=%0d required 4", word_cnt);
    end
  endtask

  task automatic test_abort();
    do_clear();
    req_a = 1'b1; req_b = 1'b1;
    cyc();
    checks++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
      errors++;
      $display("FAIL abort_first_grant: gnt_a=%b gnt_b=%b, required 1 0", gnt_a, gnt_b);
    end
    vld_a = 1'b1; data_a = 8'hAA;
    cyc();
    req_a = 1'b0; vld_a = 1'b0;
    cyc();
    checks++;
    if (s_reg_clr !== 1'b1 || s_loadl !== 1'b0 || s_word_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_pulse: reg_clr=%b loadl=%b word_valid=%b, required 1 0 0",
               s_reg_clr, s_loadl, s_word_valid);
    end
    checks++;
    if (gnt_a !== 1'b0 || gnt_b !== 1'b0 || word_cnt !== 8'd0) begin
      errors++;
      $display("FAIL abort_idle: gnt=%b%b word_cnt=%0d, required 00 0", gnt_a, gnt_b, word_cnt);
    end
    cyc();
    checks++;
    if (s_reg_clr !== 1'b0 || gnt_b !== 1'b1 || gnt_a !== 1'b0) begin
      errors++;
      $display("FAIL abort_then_b: reg_clr=%b gnt_a=%b gnt_b=%b, required 0 0 1",
               s_reg_clr, gnt_a, gnt_b);
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    do_clear();
    sb.push_back({1'b0, 8'h5C, 8'hC5});
    req_a = 1'b1;
    cyc();
    vld_a = 1'b1; data_a = 8'h5C;
    cyc();
    data_a = 8'hC5;
    cyc();
    vld_a = 1'b0; req_a = 1'b0;
    req_b = 1'b1; vld_b = 1'b1; data_b = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (s_word_valid !== 1'b1 || s_gnt_a !== 1'b1 || s_rdy_b !== 1'b0 || s_gnt_b !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: word_valid=%b gnt_a=%b gnt_b=%b rdy_b=%b, required 1 1 0 0",
                 i, s_word_valid, s_gnt_a, s_gnt_b, s_rdy_b);
      end
    end
    req_b = 1'b0; vld_b = 1'b0; word_ready = 1'b1;
    cyc();
    checks++;
    if (word_cnt !== 8'd1 || sb.size() != 0) begin
      errors++;
      $display("FAIL stall_release: word_cnt=%0d pending=%0d, required 1 0", word_cnt, sb.size());
    end
    idle_inputs();
  endtask

  task automatic test_wrap_and_clear();
    do_clear();
    for (int w = 0; w < 256; w++) sb.push_back(exp_word(1'b0, w));
    run_words(256, 0);
    checks++;
    if (word_cnt !== 8'd0) begin
      errors++;
      $display("FAIL wrap_count: word_cnt=%0d required 0", word_cnt);
    end
    sb.push_back(exp_word(1'b1, 0));
    run_words(0, 1);
    checks++;
    if (word_cnt !== 8'd1 || word_src !== 1'b1) begin
      errors++;
      $display("FAIL post_wrap_b: word_cnt=%0d word_src=%b, required 1 1", word_cnt, word_src);
    end
    req_a = 1'b1;
    cyc();
    vld_a = 1'b1; data_a = 8'h77;
    cyc();
    checks++;
    if (s_loadh !== 1'b1) begin
      errors++;
      $display("FAIL clear_setup: loadh=%b required 1", s_loadh);
    end
    // Now in LOW with vld_a still high; clear must force outputs without a clock edge.
    clear = 1'b1;
    #1;
    checks++;
    if ({gnt_a, gnt_b, word_valid, word_src, loadh, loadl, reg_clr} !== 7'b0000001 ||
        word_cnt !== 8'd0 || inh !== 8'd0 || inl !== 8'd0 || rdy_a !== 1'b0) begin
      errors++;
      $display("FAIL clear_mid_low: gnt=%b%b wv=%b src=%b lh=%b ll=%b clr=%b cnt=%0d inh=%h inl=%h rdy_a=%b, required 0 except reg_clr=1",
               gnt_a, gnt_b, word_valid, word_src, loadh, loadl, reg_clr, word_cnt, inh, inl, rdy_a);
    end
    @(posedge clk);
    #1;
    clear = 1'b0; vld_a = 1'b0;
    cyc();
    checks++;
    if (gnt_a !== 1'b1 || s_reg_clr !== 1'b0) begin
      errors++;
      $display("FAIL regrant_after_clear: gnt_a=%b reg_clr=%b, required 1 0", gnt_a, s_reg_clr);
    end
    idle_inputs();
    do_clear();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cap_hi = 0;
    cap_lo = 0;
    test_reset();
    test_single();
    test_tie();
    test_abort();
    test_stall();
    test_wrap_and_clear();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d words pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
